program_sequencer: RTL and testbench

Sequencer that feeds the 16-bit processor core: it holds a small program memory, presents one instruction at a time on the core's instruction input, and advances when the core signals completion. It also collects every value the core drives onto its output bus into an output FIFO drained by a valid/ready handshake. It sits between the test/host side and the processor.

---
 rtl/program_sequencer.sv | 147 ++++++++++++++
 tb/tb_program_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: feeds one instruction at a time from a small program
// memory to the 16-bit core, advancing on instr_done, and captures every
// core bus value into a first-word-fall-through output FIFO.
module program_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [15:0]   iin,
  input  logic          instr_done,
  input  logic [15:0]   bus,
  input  logic          bus_valid,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(OUT_DEPTH);
  localparam logic [AW:0] LEN_MAX   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state, state_n;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic [AW:0]   len;
  logic [AW:0]   len_clip;
  logic          last;
  logic [15:0]   mem0_eff;
  logic          go;

  logic [15:0]   fifo [OUT_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          fifo_full;
  logic          push_req, push, pop, ovf_set;

  assign len_clip  = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign pc_inc    = pc + AW'(1);
  assign last      = ({1'b0, pc} == len - (AW+1)'(1));
  assign go        = (state == IDLE) && start;
  // A same-cycle write to address 0 must be seen by the first fetch.
  assign mem0_eff  = (prog_we && (prog_addr == '0)) ? prog_data : mem[0];

  assign fifo_full = (count == FIFO_FULL);
  assign out_valid = (count != '0);
  assign out_data  = fifo[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push_req  = (state == RUN) && bus_valid;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = push_req && (!fifo_full || pop);
  assign ovf_set   = push_req && fifo_full && !pop;

  assign busy      = (state == RUN);
  assign done      = (state == FINISH);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = (len_clip == '0) ? FINISH : RUN;
      RUN:     if (instr_done && last) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Program memory: writable only while idle, survives reset.
  always_ff @(posedge clock) begin
    if (resetn && (state == IDLE) && prog_we) mem[prog_addr] <= prog_data;
  end

  // Program counter, run length, instruction register and sticky overflow.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc       <= '0;
      len      <= '0;
      iin      <= '0;
      overflow <= 1'b0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          iin <= '0;
          if (go) begin
            len      <= len_clip;
            pc       <= '0;
            overflow <= 1'b0;
            iin      <= (len_clip == '0) ? 16'h0000 : mem0_eff;
          end
        end
        RUN: begin
          if (instr_done) begin
            if (last) begin
              iin <= '0;
            end else begin
              pc  <= pc_inc;
              iin <= mem[pc_inc];
            end
          end
        end
        default: iin <= '0;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= bus;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a cycle model plus an output scoreboard
// queue, with targeted checks on the documented scenarios.
module tb_program_sequencer;

  localparam int DEPTH = 16;
  localparam int OUT_DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic [4:0]  prog_len;
  logic [15:0] iin;
  logic        instr_done;
  logic [15:0] bus;
  logic        bus_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  program_sequencer #(.DEPTH(DEPTH), .AW(4), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clock(clock), .resetn(resetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .prog_len(prog_len), .iin(iin),
    .instr_done(instr_done), .bus(bus), .bus_valid(bus_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int          m_state = 0;   // 0 idle, 1 run, 2 finish
  int          m_pc = 0;
  int          m_len = 0;
  logic [15:0] m_iin = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_mem [DEPTH];
  logic [15:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT,
  // then compare every output against the model.
  task automatic step();
    bit pop;
    pop = (q.size() != 0) && out_ready;
    if (pop) begin
      chk("pop_data", out_data, q[0]);
      void'(q.pop_front());
    end
    case (m_state)
      0: begin
        if (prog_we) m_mem[prog_addr] = prog_data;
        if (start) begin
          m_len = (prog_len > DEPTH) ? DEPTH : int'(prog_len);
          m_pc  = 0;
          m_ovf = 1'b0;
          if (m_len == 0) begin m_state = 2; m_iin = '0; end
          else begin m_state = 1; m_iin = m_mem[0]; end
        end
      end
      1: begin
        if (bus_valid) begin
          if (q.size() < OUT_DEPTH) q.push_back(bus);
          else m_ovf = 1'b1;
        end
        if (instr_done) begin
          if (m_pc == m_len - 1) begin m_state = 2; m_iin = '0; end
          else begin m_pc++; m_iin = m_mem[m_pc]; end
        end
      end
      default: begin m_state = 0; m_iin = '0; end
    endcase
    if (!resetn) begin
      m_state = 0; m_pc = 0; m_iin = '0; m_ovf = 1'b0; q.delete();
    end
    @(posedge clock); #1;
    chk("iin", iin, m_iin);
    chk("busy", busy, m_state == 1);
    chk("done", done, m_state == 2);
    chk("overflow", overflow, m_ovf);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic write_mem(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; prog_len = 5'(n);
    step();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0; prog_we = 0; prog_addr = '0; prog_data = '0; start = 0;
    prog_len = '0; instr_done = 0; bus = '0; bus_valid = 0; out_ready = 0;
    #1;
    step(); step();
    chk("rst_iin", iin, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    resetn = 1'b1;
    step();

    // Basic run with bus capture.
    write_mem(0, 16'h1001); write_mem(1, 16'h2002); write_mem(2, 16'h3003);
    do_start(3);
    chk("basic_iin0", iin, 16'h1001);
    chk("basic_busy", busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        bus_valid = (k == 0) && (c < 2);
        bus = (c == 0) ? 16'h00AA : 16'h0055;
        step();
      end
      bus_valid = 1'b0;
      instr_done = 1'b1; step(); instr_done = 1'b0;
      if (k == 0) chk("basic_iin1", iin, 16'h2002);
      if (k == 1) chk("basic_iin2", iin, 16'h3003);
    end
    chk("basic_done", done, 1'b1);
    chk("basic_busy_fall", busy, 1'b0);
    step();
    chk("basic_done_once", done, 1'b0);
    chk("cap_head", out_data, 16'h00AA);
    out_ready = 1'b1; step();
    chk("cap_second", out_data, 16'h0055);
    step();
    chk("cap_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Overflow: nine pushes into an eight-entry FIFO.
    do_start(1);
    bus_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin bus = 16'h0100 + 16'(i); step(); end
    bus_valid = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", out_data, 16'h0100 + 16'(i));
      step();
    end
    chk("ovf_ninth_absent", out_valid, 1'b0);
    out_ready = 1'b0;
    instr_done = 1'b1; step(); instr_done = 1'b0;
    chk("ovf_sticky", overflow, 1'b1);
    step();

    // Full FIFO with a simultaneous pop drops nothing.
    do_start(1);
    chk("ovf_cleared", overflow, 1'b0);
    bus_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin bus = 16'h0200 + 16'(i); step(); end
    bus = 16'h0208; out_ready = 1'b1;
    chk("simul_head", out_data, 16'h0200);
    step();
    bus_valid = 1'b0;
    for (int i = 1; i < 9; i++) begin
      chk("simul_drain", out_data, 16'h0200 + 16'(i));
      step();
    end
    chk("simul_empty", out_valid, 1'b0);
    chk("simul_no_ovf", overflow, 1'b0);
    out_ready = 1'b0;
    instr_done = 1'b1; step(); instr_done = 1'b0;
    step();

    // Zero length: done in the next cycle, iin stays 0.
    do_start(0);
    chk("len0_done", done, 1'b1);
    chk("len0_iin", iin, 16'h0000);
    step();

    // Length 20 clips to 16 instructions.
    for (int i = 0; i < DEPTH; i++) write_mem(i, 16'hA000 + 16'(i));
    do_start(20);
    n = 0;
    while (busy && n < 40) begin
      instr_done = 1'b1; step(); n++;
    end
    instr_done = 1'b0;
    chk("len20_count", n, 16);
    chk("len20_done", done, 1'b1);
    step();

    // start and prog_we during RUN are ignored.
    do_start(3);
    start = 1'b1; prog_len = 5'd1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hDEAD;
    step();
    start = 1'b0; prog_we = 1'b0;
    chk("ign_iin0", iin, 16'hA000);
    instr_done = 1'b1; step();
    chk("ign_iin1", iin, 16'hA001);
    step();
    chk("ign_iin2", iin, 16'hA002);
    step(); instr_done = 1'b0;
    chk("ign_done", done, 1'b1);
    step();

    // Reset mid-run at pc=2 with three FIFO entries.
    do_start(5);
    bus_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin bus = 16'h0300 + 16'(i); step(); end
    bus_valid = 1'b0;
    instr_done = 1'b1; step(); step(); instr_done = 1'b0;
    chk("mid_pc2", iin, 16'hA002);
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("mid_rst_iin", iin, 16'h0000);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    do_start(2);
    chk("mid_restart", iin, 16'hA000);
    instr_done = 1'b1; step(); step(); instr_done = 1'b0;
    step();

    // Write to address 0 and start in the same cycle.
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h5555;
    do_start(1);
    prog_we = 1'b0;
    chk("wr_start_iin", iin, 16'h5555);
    instr_done = 1'b1; step(); instr_done = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
